// File: rtl/alsu_pkg.sv
// Shared ALSU pin-interface definitions: opcodes, cmd_flags bit positions, the idle pin
// pattern and the invalid-operation rule used by the command driver.
package alsu_pkg;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    // cmd_flags = {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
    localparam int FLG_CIN       = 6;
    localparam int FLG_SERIAL_IN = 5;
    localparam int FLG_RED_A     = 4;
    localparam int FLG_RED_B     = 3;
    localparam int FLG_BYPASS_A  = 2;
    localparam int FLG_BYPASS_B  = 1;
    localparam int FLG_DIRECTION = 0;

    localparam int ALSU_OUT_W  = 6;
    localparam int ALSU_LEDS_W = 16;

    typedef struct packed {
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic [2:0]        opcode;
        logic              cin;
        logic              serial_in;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
        logic              direction;
    } alsu_pins_t;

    // Bypassing a zero A operand forces the ALSU output to 0 between commands.
    localparam alsu_pins_t ALSU_IDLE_PINS = '{
        a:         3'sd0,
        b:         3'sd0,
        opcode:    OP_OR,
        cin:       1'b0,
        serial_in: 1'b0,
        red_op_a:  1'b0,
        red_op_b:  1'b0,
        bypass_a:  1'b1,
        bypass_b:  1'b0,
        direction: 1'b0
    };

    function automatic logic alsu_is_invalid(input logic [2:0] opcode,
                                             input logic       red_a,
                                             input logic       red_b);
        return ((red_a | red_b) & (opcode[1] | opcode[2])) | (opcode[1] & opcode[2]);
    endfunction

endpackage

// File: rtl/alsu_rsp_fifo.sv
// Circular response buffer for the ALSU command driver; DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset, only the pointers and occupancy.
module alsu_rsp_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign pop_ok   = pop && rd_valid;
    // A push into a full buffer is only safe when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alsu_cmd_driver.sv
// Drives commands onto the ALSU pins and returns in-order responses after the 2-cycle ALSU latency.
// Optional leds consistency check enabled by defining ALSU_DRV_LEDS_CHECK_EN.
module alsu_cmd_driver
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_opcode,
    input  logic signed [2:0]       cmd_a,
    input  logic signed [2:0]       cmd_b,
    input  logic [6:0]              cmd_flags,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic signed [2:0]       alsu_A,
    output logic signed [2:0]       alsu_B,
    output logic [2:0]              alsu_opcode,
    output logic                    alsu_cin,
    output logic                    alsu_serial_in,
    output logic                    alsu_red_op_A,
    output logic                    alsu_red_op_B,
    output logic                    alsu_bypass_A,
    output logic                    alsu_bypass_B,
    output logic                    alsu_direction,
    input  logic signed [5:0]       alsu_out,
    input  logic [ALSU_LEDS_W-1:0]  alsu_leds,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic signed [5:0]       rsp_out,
    output logic                    rsp_invalid,
    output logic                    rsp_err,
    output logic [TAG_W-1:0]        rsp_tag
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = ALSU_OUT_W + 2 + TAG_W;

    logic             cmd_fire;
    logic             rsp_pop;
    logic [AW:0]      used;
    alsu_pins_t       cmd_pins;
    alsu_pins_t       pins_p0;

    logic             vld_p0, vld_p1, vld_p2;
    logic             inv_p0, inv_p1, inv_p2;
    logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;

    logic             cap_err;
    logic [ENT_W-1:0] cap_entry;
    logic [ENT_W-1:0] rsp_entry;

    assign cmd_ready = (used < (AW+1)'(DEPTH));
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_comb begin
        cmd_pins           = ALSU_IDLE_PINS;
        cmd_pins.a         = cmd_a;
        cmd_pins.b         = cmd_b;
        cmd_pins.opcode    = cmd_opcode;
        cmd_pins.cin       = cmd_flags[FLG_CIN];
        cmd_pins.serial_in = cmd_flags[FLG_SERIAL_IN];
        cmd_pins.red_op_a  = cmd_flags[FLG_RED_A];
        cmd_pins.red_op_b  = cmd_flags[FLG_RED_B];
        cmd_pins.bypass_a  = cmd_flags[FLG_BYPASS_A];
        cmd_pins.bypass_b  = cmd_flags[FLG_BYPASS_B];
        cmd_pins.direction = cmd_flags[FLG_DIRECTION];
    end

    // Stage p0: pins hold an accepted command for exactly one cycle, idle otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_p0 <= ALSU_IDLE_PINS;
        end else begin
            pins_p0 <= cmd_fire ? cmd_pins : ALSU_IDLE_PINS;
        end
    end

    assign alsu_A         = pins_p0.a;
    assign alsu_B         = pins_p0.b;
    assign alsu_opcode    = pins_p0.opcode;
    assign alsu_cin       = pins_p0.cin;
    assign alsu_serial_in = pins_p0.serial_in;
    assign alsu_red_op_A  = pins_p0.red_op_a;
    assign alsu_red_op_B  = pins_p0.red_op_b;
    assign alsu_bypass_A  = pins_p0.bypass_a;
    assign alsu_bypass_B  = pins_p0.bypass_b;
    assign alsu_direction = pins_p0.direction;

    // Stages p0..p2: in-flight tracking; never stalls because credits reserve a FIFO slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= cmd_fire;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        inv_p0 <= alsu_is_invalid(cmd_opcode, cmd_flags[FLG_RED_A], cmd_flags[FLG_RED_B]);
        tag_p0 <= cmd_tag;
        inv_p1 <= inv_p0;
        tag_p1 <= tag_p0;
        inv_p2 <= inv_p1;
        tag_p2 <= tag_p1;
    end

`ifdef ALSU_DRV_LEDS_CHECK_EN
    logic [ALSU_LEDS_W-1:0] leds_prev;
    logic [ALSU_LEDS_W-1:0] leds_exp;

    // leds_prev trails the ALSU by one cycle, i.e. the value before the capture op updated it.
    always_ff @(posedge clk) begin
        leds_prev <= alsu_leds;
    end

    assign leds_exp = inv_p2 ? ~leds_prev : '0;
    assign cap_err  = (alsu_leds != leds_exp);
`else
    logic unused_leds;
    assign unused_leds = ^alsu_leds;
    assign cap_err     = 1'b0;
`endif

    // Capture stage: the result launched three edges ago is on alsu_out now.
    assign cap_entry = {alsu_out, inv_p2, cap_err, tag_p2};

    alsu_rsp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENT_W)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (vld_p2),
        .wr_data  (cap_entry),
        .pop      (rsp_pop),
        .rd_valid (rsp_valid),
        .rd_data  (rsp_entry)
    );

    assign rsp_out     = rsp_entry[ENT_W-1 -: ALSU_OUT_W];
    assign rsp_invalid = rsp_entry[TAG_W+1];
    assign rsp_err     = rsp_entry[TAG_W];
    assign rsp_tag     = rsp_entry[TAG_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used <= '0;
        end else begin
            case ({cmd_fire, rsp_pop})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Directed bench for alsu_cmd_driver with a behavioural ALSU and an in-order response scoreboard.
module tb_alsu_cmd_driver;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_CIN   = 7'b1000000;
    localparam logic [6:0] F_BYP_A = 7'b0000100;
    localparam logic [6:0] F_DIR   = 7'b0000001;
    localparam logic [15:0] IDLE_PINS_VEC = {3'd0, 3'd0, 3'd0, 7'b0000100};

`ifdef ALSU_DRV_LEDS_CHECK_EN
    localparam logic EXP_FORCED_ERR = 1'b1;
`else
    localparam logic EXP_FORCED_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [2:0]       cmd_a;
    logic [2:0]       cmd_b;
    logic [6:0]       cmd_flags;
    logic [TAG_W-1:0] cmd_tag;
    logic [2:0]       alsu_A, alsu_B, alsu_opcode;
    logic             alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic             alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0]       alsu_out;
    logic [15:0]      alsu_leds;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [5:0]       rsp_out;
    logic             rsp_invalid;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             leds_force;

    always #5 clk = ~clk;

    alsu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flags(cmd_flags), .cmd_tag(cmd_tag),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin),
        .alsu_serial_in(alsu_serial_in), .alsu_red_op_A(alsu_red_op_A),
        .alsu_red_op_B(alsu_red_op_B), .alsu_bypass_A(alsu_bypass_A),
        .alsu_bypass_B(alsu_bypass_B), .alsu_direction(alsu_direction),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_invalid(rsp_invalid), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    // Behavioural ALSU: inputs registered, outputs registered one cycle later.
    logic [2:0]  m_a, m_b, m_op;
    logic        m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir;
    logic [5:0]  m_out;
    logic [15:0] m_leds;
    wire         m_inv = ((m_ra | m_rb) & (m_op[1] | m_op[2])) | (m_op[1] & m_op[2]);
    wire  [5:0]  m_ax  = {{3{m_a[2]}}, m_a};
    wire  [5:0]  m_bx  = {{3{m_b[2]}}, m_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_a, m_b, m_op, m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir} <= '0;
        end else begin
            {m_a, m_b, m_op} <= {alsu_A, alsu_B, alsu_opcode};
            {m_cin, m_si, m_ra, m_rb} <= {alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B};
            {m_ba, m_bb, m_dir} <= {alsu_bypass_A, alsu_bypass_B, alsu_direction};
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out  <= '0;
            m_leds <= '0;
        end else if (m_inv) begin
            m_out  <= '0;
            m_leds <= ~m_leds;
        end else begin
            m_leds <= '0;
            if (m_ba)      m_out <= m_ax;
            else if (m_bb) m_out <= m_bx;
            else begin
                case (m_op)
                    3'd0:    m_out <= m_ra ? {5'd0, |m_a} : m_rb ? {5'd0, |m_b} : {3'd0, m_a | m_b};
                    3'd1:    m_out <= m_ra ? {5'd0, ^m_a} : m_rb ? {5'd0, ^m_b} : {3'd0, m_a ^ m_b};
                    3'd2:    m_out <= m_ax + m_bx + {5'd0, m_cin};
                    3'd3:    m_out <= m_ax * m_bx;
                    3'd4:    m_out <= m_dir ? {m_out[4:0], m_si} : {m_si, m_out[5:1]};
                    3'd5:    m_out <= m_dir ? {m_out[4:0], m_out[5]} : {m_out[0], m_out[5:1]};
                    default: m_out <= '0;
                endcase
            end
        end
    end

    assign alsu_out  = m_out;
    assign alsu_leds = leds_force ? 16'h0001 : m_leds;

    typedef struct packed {
        logic [5:0]       out;
        logic             inv;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard consumer: every handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {28'd0, rsp_tag}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_tag",     {28'd0, rsp_tag},   {28'd0, mon_e.tag});
                chk("rsp_out",     {26'd0, rsp_out},   {26'd0, mon_e.out});
                chk("rsp_invalid", {31'd0, rsp_invalid}, {31'd0, mon_e.inv});
                chk("rsp_err",     {31'd0, rsp_err},   {31'd0, mon_e.err});
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [6:0] fl, input logic [TAG_W-1:0] tg,
                        input logic [5:0] eo, input logic ei, input logic ee);
        logic rdy;
        int   n;
        n          = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_flags  = fl;
        cmd_tag    = tg;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        else      sb_q.push_back('{out: eo, inv: ei, err: ee, tag: tg});
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pins_vec();
        return {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_red_op_A,
                alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};
    endfunction

    initial begin
        logic [5:0]       hold_out;
        logic [TAG_W-1:0] hold_tag;
        int               n;
        int               stale;

        rst_n = 1'b0; rsp_ready = 1'b1; leds_force = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_flags = '0; cmd_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_pins_idle", {16'd0, pins_vec()}, {16'd0, IDLE_PINS_VEC});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ADD 3+2+1 with latency and one-cycle pin pulse
        send(3'd2, 3'd3, 3'd2, F_CIN, 4'd1, 6'd6, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pins_cmd", {16'd0, pins_vec()}, {16'd0, 3'd3, 3'd2, 3'd2, F_CIN});
        @(negedge clk);
        chk("pins_idle_after", {16'd0, pins_vec()}, {16'd0, IDLE_PINS_VEC});
        n = 2;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("add_latency", n - 1, 32'd3);
        wait_drain("drain_add");

        // Invalid ops back-to-back: leds toggle FFFF then 0000
        send(3'd6, 3'd0, 3'd0, F_NONE, 4'd2, 6'd0, 1'b1, 1'b0);
        send(3'd7, 3'd0, 3'd0, F_NONE, 4'd3, 6'd0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        wait_drain("drain_invalid");

        // Backpressure: four credits, then stall, then in-order release
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(3'd2, 3'((t + 1) / 2), 3'(t / 2), F_NONE, TAG_W'(t), 6'(t), 1'b0, 1'b0);
        end
        cmd_valid = 1'b1; cmd_opcode = 3'd2; cmd_a = 3'd2; cmd_b = 3'd2;
        cmd_flags = F_NONE; cmd_tag = 4'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0 || i == 5) chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_head_tag", {28'd0, rsp_tag}, 32'd0);
        hold_out = rsp_out;
        hold_tag = rsp_tag;
        repeat (2) @(negedge clk);
        chk("bp_hold_out", {26'd0, rsp_out}, {26'd0, hold_out});
        chk("bp_hold_tag", {28'd0, rsp_tag}, {28'd0, hold_tag});
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(3'd2, 3'd2, 3'd2, F_NONE, 4'd4, 6'd4, 1'b0, 1'b0);
        send(3'd2, 3'd3, 3'd2, F_NONE, 4'd5, 6'd5, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_drain("drain_bp");

        // Shift chain back-to-back, then with one idle gap
        send(3'd0, 3'b111, 3'd0, F_BYP_A, 4'd6, 6'h3F, 1'b0, 1'b0);
        send(3'd4, 3'd0, 3'd0, F_DIR, 4'd7, 6'h3E, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_drain("drain_shift");
        send(3'd0, 3'b111, 3'd0, F_BYP_A, 4'd8, 6'h3F, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        send(3'd4, 3'd0, 3'd0, F_DIR, 4'd9, 6'h00, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_drain("drain_shift_gap");

        // Reset with one queued and two in flight
        rsp_ready = 1'b0;
        send(3'd2, 3'd1, 3'd1, F_NONE, 4'd10, 6'd2, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(3'd2, 3'd1, 3'd0, F_NONE, 4'd11, 6'd1, 1'b0, 1'b0);
        send(3'd2, 3'd0, 3'd1, F_NONE, 4'd12, 6'd1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("postrst_no_stale", stale, 32'd0);
        @(posedge clk);
        #1;
        send(3'd3, 3'd2, 3'd3, F_NONE, 4'd13, 6'd6, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_drain("drain_postrst");

        // Forced leds mismatch on a valid op
        leds_force = 1'b1;
        send(3'd2, 3'd1, 3'd1, F_NONE, 4'd14, 6'd2, 1'b0, EXP_FORCED_ERR);
        cmd_valid = 1'b0;
        wait_drain("drain_leds");
        leds_force = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
